// File: rtl/siso_scan_arbiter_if.sv
// Client and chain-side signal bundle for siso_scan_arbiter.
// The slave modport is the arbiter; the master modport is the clients plus the chain.
interface siso_scan_arbiter_if #(parameter int W = 4);
  logic         req0;
  logic         req1;
  logic [W-1:0] wdata0;
  logic [W-1:0] wdata1;
  logic         done0;
  logic         done1;
  logic [W-1:0] rdata;
  logic         busy;
  logic         sr_si;
  logic         sr_en;
  logic         sr_so;

  modport slave (
    input  req0, req1, wdata0, wdata1, sr_so,
    output done0, done1, rdata, busy, sr_si, sr_en
  );

  modport master (
    output req0, req1, wdata0, wdata1, sr_so,
    input  done0, done1, rdata, busy, sr_si, sr_en
  );
endinterface

// File: rtl/siso_scan_arbiter.sv
// Two-client arbiter that scans a word into a shared W-stage SISO chain while capturing its old contents.
// Optional macro ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed priority to req0.
module siso_scan_arbiter #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  siso_scan_arbiter_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          any_req;
  logic          winner;
  logic [1:0][W-1:0] wdata_a;

  assign wdata_a = {bus.wdata1, bus.wdata0};
  assign any_req = bus.req0 | bus.req1;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  // On a tie the requester that did not go last wins.
  always_comb begin
    winner = ~bus.req0;
    if (bus.req0 && bus.req1) winner = ~last_q;
  end
`else
  always_comb begin
    winner = ~bus.req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          sreg_d  = wdata_a[winner];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // MSB leaves on sr_si while the chain's outgoing bit refills the LSB.
        sreg_d = {sreg_q[W-2:0], bus.sr_so};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = DONE;
      end
      DONE: begin
`ifdef ARB_RR_EN
        last_d  = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sr_en = 1'b0;
    bus.sr_si = 1'b0;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    bus.rdata = '0;
    bus.busy  = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.sr_en = 1'b1;
        bus.sr_si = sreg_q[W-1];
        bus.busy  = 1'b1;
      end
      DONE: begin
        bus.done0 = ~owner_q;
        bus.done1 = owner_q;
        bus.rdata = sreg_q;
        bus.busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_RR_EN
  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

endmodule

// File: doc/siso_scan_arbiter.md
# siso_scan_arbiter

Two-requester arbiter and sequencer for a single serial-in/serial-out shift chain. The chain is the W-stage SISO register with an added shift enable. A granted requester's parallel word is scanned into the chain MSB-first over W cycles. At the same time, the chain's previous contents are captured from the serial output and returned as a parallel word. The block sits between the two clients and the one shared chain, so neither client drives the chain directly.

## Interface
- W, default 4: chain length in bits, and the width of wdata/rdata; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  level request; the requester holds it high until its done pulse.
- wdata0, wdata1  in  W  word to scan in; must stay stable while the matching req is high.
- done0, done1  out  1  one-cycle completion pulse to the granted requester.
- rdata  out  W  previous chain contents; valid only while done0 or done1 is high.
- busy  out  1  high in SHIFT and DONE.
- sr_si  out  1  serial data to chain stage 0.
- sr_en  out  1  chain shift enable; on each enabled edge: chain <= {chain[W-2:0], sr_si}.
- sr_so  in  1  chain stage W-1, combinational, sampled before the shift.

## Operation
- The state machine is IDLE → SHIFT → DONE → IDLE. Internal registers:
  - sreg[W-1:0] holds the shift data.
  - cnt holds the shift count, ceil(log2 W) bits.
  - owner is 1 bit.
  - last is 1 bit, the round-robin pointer.
- IDLE: requests are sampled only in this state.
  - If any req is high at the edge, select the winner, then set owner <= winner, sreg <= wdata[winner], cnt <= 0, and go to SHIFT.
  - With no req, stay in IDLE.
- SHIFT: sr_en = 1 and sr_si = sreg[W-1].
  - Each edge: sreg <= {sreg[W-2:0], sr_so} and cnt <= cnt+1.
  - At the edge where cnt == W-1, go to DONE.
  - After exactly W shifts, the chain holds the winner's wdata and sreg holds the old chain contents, MSB = old stage W-1.
- DONE: done[owner] = 1 and rdata = sreg. At the next edge: last <= owner, then go to IDLE.
- Outside SHIFT: sr_en = 0 and sr_si = 0. Outside DONE: done0 = done1 = 0 and rdata = 0.
- A requester must drop req no later than the edge that ends its DONE cycle. If req is still high in the following IDLE cycle, it is treated as a new transaction.
- A req that rises or falls during SHIFT or DONE has no effect on the transaction in flight.
- If both requests arrive in the same cycle, the arbitration rule under Configuration decides the winner.

## Timing
- All reset values are applied asynchronously on rst:
  - state = IDLE, sreg = 0, cnt = 0, owner = 0, last = 1 (so requester 0 wins first).
  - All outputs are 0.
- Latency:
  - req is seen in IDLE at cycle 0.
  - sr_en is high in cycles 1..W.
  - done is high in cycle W+1.
  - The next IDLE is cycle W+2.
- Back-to-back throughput is one transaction every W+2 cycles.
- If rst is asserted mid-SHIFT or mid-DONE:
  - The transaction is aborted immediately and no done pulse is issued.
  - The chain keeps whatever has been partially shifted in; nothing is rolled back.
  - The requester must re-request after reset.
- sr_so is sampled on the same edge that applies the shift, so the chain must present stage W-1 combinationally.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a tie, the requester that is not `last` wins, so the two alternate under continuous contention.
- ARB_RR_EN undefined: fixed priority, where req0 always wins ties. The `last` register is not implemented, and req1 can starve.

## Test plan
- Single request, W=4, chain preloaded 4'b1010: req0 with wdata0 = 4'b0110 → sr_en high for exactly cycles 1–4, sr_si sequence 0,1,1,0, done0 in cycle 5 with rdata = 4'b1010, chain = 0110 afterwards.
- Back-to-back from one client: req0 with wdata 4'b1111, then immediately 4'b0001 → second done0 carries rdata = 4'b1111, and the two done pulses are 6 cycles apart.
- Simultaneous req0 = req1 held high, with ARB_RR_EN defined → grants alternate 0,1,0,1. With ARB_RR_EN undefined → grants are 0,0,0…, and done1 never pulses.
- req1 rises during req0's SHIFT → req0's transaction completes unaffected, and req1 is granted in the IDLE cycle following done0.
- rst pulsed in SHIFT cycle 2 → busy, sr_en and done drop to 0 immediately, state is IDLE, no done pulse is issued, and the next request completes normally.
- Idle with no requests for 20 cycles → sr_en = 0, sr_si = 0 and busy = 0 throughout.
